// File: rtl/ball_collision_resolver.sv
// Per-frame two-ball collision controller: latches both balls, resolves ball-ball
// swap and cushion bounces, then pulses velocity writes back to each ball.
module ball_collision_resolver #(
  parameter int DATA_W       = 11,
  parameter int BALL_SIZE    = 32,
  parameter int TABLE_LEFT   = 16,
  parameter int TABLE_RIGHT  = 624,
  parameter int TABLE_TOP    = 16,
  parameter int TABLE_BOTTOM = 464
) (
  input  logic                     clk,
  input  logic                     resetN,
  input  logic                     startOfFrame,
  input  logic signed [DATA_W-1:0] posAX,
  input  logic signed [DATA_W-1:0] posAY,
  input  logic signed [DATA_W-1:0] velAX,
  input  logic signed [DATA_W-1:0] velAY,
  input  logic signed [DATA_W-1:0] posBX,
  input  logic signed [DATA_W-1:0] posBY,
  input  logic signed [DATA_W-1:0] velBX,
  input  logic signed [DATA_W-1:0] velBY,
  output logic                     writeEnableA,
  output logic signed [DATA_W-1:0] outVelAX,
  output logic signed [DATA_W-1:0] outVelAY,
  output logic                     writeEnableB,
  output logic signed [DATA_W-1:0] outVelBX,
  output logic signed [DATA_W-1:0] outVelBY,
  output logic                     hitPulse,
  output logic                     busy
);

  localparam int DW   = DATA_W + 1;
  localparam int PW   = 2 * DW;
  localparam int DOTW = PW + 1;
  localparam int CW   = DATA_W + 2;

  localparam logic [PW-1:0]           RADIUS2  = PW'(BALL_SIZE * BALL_SIZE);
  localparam logic signed [CW-1:0]    SIZE_C   = CW'(BALL_SIZE);
  localparam logic signed [CW-1:0]    LEFT_C   = CW'(TABLE_LEFT);
  localparam logic signed [CW-1:0]    RIGHT_C  = CW'(TABLE_RIGHT);
  localparam logic signed [CW-1:0]    TOP_C    = CW'(TABLE_TOP);
  localparam logic signed [CW-1:0]    BOTTOM_C = CW'(TABLE_BOTTOM);
  localparam logic signed [DATA_W-1:0] MIN_V   = {1'b1, {(DATA_W-1){1'b0}}};
  localparam logic signed [DATA_W-1:0] MAX_V   = {1'b0, {(DATA_W-1){1'b1}}};

  typedef enum logic [2:0] {IDLE, LATCH, CALC, RESOLVE, WRITE} state_t;

  // Negation with the single unrepresentable case (most negative) clamped.
  function automatic logic signed [DATA_W-1:0] neg_sat(input logic signed [DATA_W-1:0] v);
    if (v == MIN_V) return MAX_V;
    return -v;
  endfunction

  function automatic logic signed [DATA_W-1:0] cushion(
    input logic signed [DATA_W-1:0] pos,
    input logic signed [DATA_W-1:0] v,
    input logic signed [CW-1:0]     lo,
    input logic signed [CW-1:0]     hi
  );
    logic signed [CW-1:0] p;
    logic                 v_neg;
    logic                 v_pos;
    p     = CW'(pos);
    v_neg = v[DATA_W-1];
    v_pos = !v[DATA_W-1] && (v != '0);
    if ((p <= lo && v_neg) || ((p + SIZE_C) >= hi && v_pos)) return neg_sat(v);
    return v;
  endfunction

  state_t                   state_q, state_d;
  logic signed [DATA_W-1:0] pos_ax_q, pos_ay_q, pos_bx_q, pos_by_q;
  logic signed [DATA_W-1:0] pos_ax_d, pos_ay_d, pos_bx_d, pos_by_d;
  logic signed [DATA_W-1:0] vel_ax_q, vel_ay_q, vel_bx_q, vel_by_q;
  logic signed [DATA_W-1:0] vel_ax_d, vel_ay_d, vel_bx_d, vel_by_d;
  logic signed [DW-1:0]     dx_q, dy_q, dvx_q, dvy_q;
  logic signed [DW-1:0]     dx_d, dy_d, dvx_d, dvy_d;
  logic [PW-1:0]            dist2_q, dist2_d;
  logic signed [DOTW-1:0]   dot_q, dot_d;
  logic signed [DATA_W-1:0] out_ax_q, out_ay_q, out_bx_q, out_by_q;
  logic signed [DATA_W-1:0] out_ax_d, out_ay_d, out_bx_d, out_by_d;
  logic                     we_a_q, we_a_d, we_b_q, we_b_d, hit_q, hit_d;

  logic                     collide;
  logic signed [DATA_W-1:0] swap_ax, swap_ay, swap_bx, swap_by;
  logic signed [DATA_W-1:0] res_ax, res_ay, res_bx, res_by;

  // Resolution datapath: swap first, then cushion bounce on the swapped vectors.
  always_comb begin
    collide = (dist2_q < RADIUS2) && dot_q[DOTW-1];
    swap_ax = collide ? vel_bx_q : vel_ax_q;
    swap_ay = collide ? vel_by_q : vel_ay_q;
    swap_bx = collide ? vel_ax_q : vel_bx_q;
    swap_by = collide ? vel_ay_q : vel_by_q;
    res_ax  = cushion(pos_ax_q, swap_ax, LEFT_C, RIGHT_C);
    res_ay  = cushion(pos_ay_q, swap_ay, TOP_C,  BOTTOM_C);
    res_bx  = cushion(pos_bx_q, swap_bx, LEFT_C, RIGHT_C);
    res_by  = cushion(pos_by_q, swap_by, TOP_C,  BOTTOM_C);
  end

  always_comb begin
    state_d  = state_q;
    pos_ax_d = pos_ax_q;  pos_ay_d = pos_ay_q;
    pos_bx_d = pos_bx_q;  pos_by_d = pos_by_q;
    vel_ax_d = vel_ax_q;  vel_ay_d = vel_ay_q;
    vel_bx_d = vel_bx_q;  vel_by_d = vel_by_q;
    dx_d     = dx_q;      dy_d     = dy_q;
    dvx_d    = dvx_q;     dvy_d    = dvy_q;
    dist2_d  = dist2_q;   dot_d    = dot_q;
    out_ax_d = out_ax_q;  out_ay_d = out_ay_q;
    out_bx_d = out_bx_q;  out_by_d = out_by_q;
    we_a_d   = 1'b0;
    we_b_d   = 1'b0;
    hit_d    = 1'b0;
    case (state_q)
      IDLE: begin
        if (startOfFrame) state_d = LATCH;
      end
      LATCH: begin
        pos_ax_d = posAX;  pos_ay_d = posAY;
        pos_bx_d = posBX;  pos_by_d = posBY;
        vel_ax_d = velAX;  vel_ay_d = velAY;
        vel_bx_d = velBX;  vel_by_d = velBY;
        dx_d     = DW'(posBX) - DW'(posAX);
        dy_d     = DW'(posBY) - DW'(posAY);
        dvx_d    = DW'(velBX) - DW'(velAX);
        dvy_d    = DW'(velBY) - DW'(velAY);
        state_d  = CALC;
      end
      CALC: begin
        dist2_d = $unsigned(PW'(dx_q) * PW'(dx_q) + PW'(dy_q) * PW'(dy_q));
        dot_d   = DOTW'(dx_q) * DOTW'(dvx_q) + DOTW'(dy_q) * DOTW'(dvy_q);
        state_d = RESOLVE;
      end
      RESOLVE: begin
        out_ax_d = res_ax;  out_ay_d = res_ay;
        out_bx_d = res_bx;  out_by_d = res_by;
        we_a_d   = (res_ax != vel_ax_q) || (res_ay != vel_ay_q);
        we_b_d   = (res_bx != vel_bx_q) || (res_by != vel_by_q);
        hit_d    = collide;
        state_d  = WRITE;
      end
      WRITE: begin
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state_q  <= IDLE;
      pos_ax_q <= '0;  pos_ay_q <= '0;  pos_bx_q <= '0;  pos_by_q <= '0;
      vel_ax_q <= '0;  vel_ay_q <= '0;  vel_bx_q <= '0;  vel_by_q <= '0;
      dx_q     <= '0;  dy_q     <= '0;  dvx_q    <= '0;  dvy_q    <= '0;
      dist2_q  <= '0;  dot_q    <= '0;
      out_ax_q <= '0;  out_ay_q <= '0;  out_bx_q <= '0;  out_by_q <= '0;
      we_a_q   <= 1'b0;
      we_b_q   <= 1'b0;
      hit_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      pos_ax_q <= pos_ax_d;  pos_ay_q <= pos_ay_d;
      pos_bx_q <= pos_bx_d;  pos_by_q <= pos_by_d;
      vel_ax_q <= vel_ax_d;  vel_ay_q <= vel_ay_d;
      vel_bx_q <= vel_bx_d;  vel_by_q <= vel_by_d;
      dx_q     <= dx_d;      dy_q     <= dy_d;
      dvx_q    <= dvx_d;     dvy_q    <= dvy_d;
      dist2_q  <= dist2_d;   dot_q    <= dot_d;
      out_ax_q <= out_ax_d;  out_ay_q <= out_ay_d;
      out_bx_q <= out_bx_d;  out_by_q <= out_by_d;
      we_a_q   <= we_a_d;
      we_b_q   <= we_b_d;
      hit_q    <= hit_d;
    end
  end

  assign writeEnableA = we_a_q;
  assign writeEnableB = we_b_q;
  assign hitPulse     = hit_q;
  assign outVelAX     = out_ax_q;
  assign outVelAY     = out_ay_q;
  assign outVelBX     = out_bx_q;
  assign outVelBY     = out_by_q;
  assign busy         = (state_q != IDLE);

endmodule

// File: tb/tb_ball_collision_resolver.sv
// Bench for ball_collision_resolver: directed table cases plus random frames,
// all checked every cycle against an integer reference of the frame rules.
module tb_ball_collision_resolver;

  logic               clk = 1'b0;
  logic               resetN;
  logic               startOfFrame;
  logic signed [10:0] posAX, posAY, velAX, velAY, posBX, posBY, velBX, velBY;
  logic               writeEnableA, writeEnableB, hitPulse, busy;
  logic signed [10:0] outVelAX, outVelAY, outVelBX, outVelBY;

  int tests = 0;
  int fails = 0;

  ball_collision_resolver dut (
    .clk(clk), .resetN(resetN), .startOfFrame(startOfFrame),
    .posAX(posAX), .posAY(posAY), .velAX(velAX), .velAY(velAY),
    .posBX(posBX), .posBY(posBY), .velBX(velBX), .velBY(velBY),
    .writeEnableA(writeEnableA), .outVelAX(outVelAX), .outVelAY(outVelAY),
    .writeEnableB(writeEnableB), .outVelBX(outVelBX), .outVelBY(outVelBY),
    .hitPulse(hitPulse), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Reference rules in plain integer arithmetic.
  function automatic int cush(input int p, input int v, input int lo, input int hi);
    if ((p <= lo && v < 0) || (p + 32 >= hi && v > 0)) return (-v > 1023) ? 1023 : -v;
    return v;
  endfunction

  function automatic void model(
    input int ax, ay, avx, avy, bx, by, bvx, bvy,
    output int rax, ray, rbx, rby, output bit wa, wb, hit
  );
    int dx, dy, dist2, dot;
    dx    = bx - ax;
    dy    = by - ay;
    dist2 = dx * dx + dy * dy;
    dot   = dx * (bvx - avx) + dy * (bvy - avy);
    hit   = (dist2 < 32 * 32) && (dot < 0);
    rax   = cush(ax, hit ? bvx : avx, 16, 624);
    ray   = cush(ay, hit ? bvy : avy, 16, 464);
    rbx   = cush(bx, hit ? avx : bvx, 16, 624);
    rby   = cush(by, hit ? avy : bvy, 16, 464);
    wa    = (rax != avx) || (ray != avy);
    wb    = (rbx != bvx) || (rby != bvy);
  endfunction

  // Frame timing: four busy cycles after a sampled start, results in the last.
  int phase = 0;
  int exp_ax = 0, exp_ay = 0, exp_bx = 0, exp_by = 0;
  int p_ax, p_ay, p_bx, p_by;
  bit exp_wa = 0, exp_wb = 0, exp_hit = 0;
  bit p_wa, p_wb, p_hit;

  always @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      phase = 0;
      exp_ax = 0; exp_ay = 0; exp_bx = 0; exp_by = 0;
      exp_wa = 0; exp_wb = 0; exp_hit = 0;
    end else begin
      exp_wa = 0; exp_wb = 0; exp_hit = 0;
      if (phase == 0) begin
        if (startOfFrame) begin
          phase = 1;
          model(posAX, posAY, velAX, velAY, posBX, posBY, velBX, velBY,
                p_ax, p_ay, p_bx, p_by, p_wa, p_wb, p_hit);
        end
      end else if (phase == 3) begin
        phase  = 4;
        exp_ax = p_ax; exp_ay = p_ay; exp_bx = p_bx; exp_by = p_by;
        exp_wa = p_wa; exp_wb = p_wb; exp_hit = p_hit;
      end else if (phase == 4) begin
        phase = 0;
      end else begin
        phase++;
      end
    end
  end

  int cnt_wa = 0, cnt_wb = 0, cnt_hit = 0, cnt_busy = 0;

  always begin
    @(posedge clk);
    #2;
    chk("busy", busy, phase != 0);
    chk("writeEnableA", writeEnableA, exp_wa);
    chk("writeEnableB", writeEnableB, exp_wb);
    chk("hitPulse", hitPulse, exp_hit);
    chk("outVelAX", outVelAX, exp_ax);
    chk("outVelAY", outVelAY, exp_ay);
    chk("outVelBX", outVelBX, exp_bx);
    chk("outVelBY", outVelBY, exp_by);
    cnt_wa   += int'(writeEnableA);
    cnt_wb   += int'(writeEnableB);
    cnt_hit  += int'(hitPulse);
    cnt_busy += int'(busy);
  end

  task automatic set_balls(input int ax, ay, avx, avy, bx, by, bvx, bvy);
    posAX = 11'(ax); posAY = 11'(ay); velAX = 11'(avx); velAY = 11'(avy);
    posBX = 11'(bx); posBY = 11'(by); velBX = 11'(bvx); velBY = 11'(bvy);
  endtask

  // Pulses start once (or twice when dbl is set) and returns pulse counts seen.
  task automatic run_frame(input bit dbl, output int wa, wb, hit, bz);
    int wa0, wb0, hit0, bz0;
    wa0 = cnt_wa; wb0 = cnt_wb; hit0 = cnt_hit; bz0 = cnt_busy;
    @(negedge clk) startOfFrame = 1'b1;
    @(negedge clk) startOfFrame = 1'b0;
    if (dbl) begin
      @(negedge clk);
      startOfFrame = 1'b1;
      @(negedge clk) startOfFrame = 1'b0;
      repeat (4) @(negedge clk);
    end else begin
      repeat (5) @(negedge clk);
    end
    wa = cnt_wa - wa0; wb = cnt_wb - wb0; hit = cnt_hit - hit0; bz = cnt_busy - bz0;
  endtask

  initial begin
    int wa, wb, hit, bz;
    int m_ax, m_ay, m_bx, m_by;
    bit m_wa, m_wb, m_hit;
    int ax, ay, bx, by;

    resetN = 1'b0;
    startOfFrame = 1'b0;
    set_balls(0, 0, 0, 0, 0, 0, 0, 0);
    repeat (3) @(negedge clk);
    chk("reset_busy", busy, 0);
    chk("reset_weA", writeEnableA, 0);
    chk("reset_outVelBX", outVelBX, 0);
    resetN = 1'b1;

    // Hand-computed pins on the reference itself.
    model(100, 100, 64, 0, 120, 100, 0, 0, m_ax, m_ay, m_bx, m_by, m_wa, m_wb, m_hit);
    chk("pin_headon_ax", m_ax, 0);
    chk("pin_headon_bx", m_bx, 64);
    chk("pin_headon_hit", int'(m_hit), 1);
    chk("pin_sat", cush(10, -1024, 16, 624), 1023);

    // Head-on hit.
    set_balls(100, 100, 64, 0, 120, 100, 0, 0);
    run_frame(0, wa, wb, hit, bz);
    chk("headon_weA_count", wa, 1);
    chk("headon_weB_count", wb, 1);
    chk("headon_hit_count", hit, 1);
    chk("headon_outVelAX", outVelAX, 0);
    chk("headon_outVelBX", outVelBX, 64);

    // Separating overlap.
    set_balls(100, 100, 0, 0, 120, 100, 64, 0);
    run_frame(0, wa, wb, hit, bz);
    chk("sep_writes", wa + wb, 0);
    chk("sep_hit_count", hit, 0);
    chk("sep_busy_cycles", bz, 4);

    // Right cushion.
    set_balls(600, 200, 40, -10, 300, 300, 0, 0);
    run_frame(0, wa, wb, hit, bz);
    chk("right_outVelAX", outVelAX, -40);
    chk("right_outVelAY", outVelAY, -10);
    chk("right_weA_count", wa, 1);
    chk("right_weB_count", wb, 0);
    chk("right_hit_count", hit, 0);

    // Corner with saturation.
    set_balls(10, 10, -1024, -7, 300, 300, 0, 0);
    run_frame(0, wa, wb, hit, bz);
    chk("corner_outVelAX", outVelAX, 1023);
    chk("corner_outVelAY", outVelAY, 7);
    chk("corner_weA_count", wa, 1);

    // Start pulse while busy is ignored.
    set_balls(100, 100, 64, 0, 120, 100, 0, 0);
    run_frame(1, wa, wb, hit, bz);
    chk("dbl_weA_count", wa, 1);
    chk("dbl_hit_count", hit, 1);
    chk("dbl_busy_cycles", bz, 4);

    // Reset during CALC aborts the frame.
    @(negedge clk) startOfFrame = 1'b1;
    @(negedge clk) startOfFrame = 1'b0;
    @(negedge clk) resetN = 1'b0;
    #1;
    chk("abort_busy", busy, 0);
    chk("abort_outVelBX", outVelBX, 0);
    chk("abort_weA", writeEnableA, 0);
    @(negedge clk) resetN = 1'b1;
    wa = cnt_wa; hit = cnt_hit;
    repeat (6) @(negedge clk);
    chk("abort_no_write", cnt_wa - wa, 0);
    chk("abort_no_hit", cnt_hit - hit, 0);
    run_frame(0, wa, wb, hit, bz);
    chk("after_abort_weB_count", wb, 1);
    chk("after_abort_outVelBX", outVelBX, 64);

    // Random frames, often with the balls close together or near cushions.
    for (int i = 0; i < 80; i++) begin
      ax = $urandom_range(0, 650);
      ay = $urandom_range(0, 490);
      if ($urandom_range(0, 1) == 1) begin
        bx = ax + $urandom_range(0, 80) - 40;
        by = ay + $urandom_range(0, 80) - 40;
      end else begin
        bx = $urandom_range(0, 650);
        by = $urandom_range(0, 490);
      end
      set_balls(ax, ay,
                ($urandom_range(0, 3) == 0) ? $urandom_range(0, 2047) - 1024 : $urandom_range(0, 200) - 100,
                ($urandom_range(0, 3) == 0) ? $urandom_range(0, 2047) - 1024 : $urandom_range(0, 200) - 100,
                bx, by,
                ($urandom_range(0, 3) == 0) ? $urandom_range(0, 2047) - 1024 : $urandom_range(0, 200) - 100,
                ($urandom_range(0, 3) == 0) ? $urandom_range(0, 2047) - 1024 : $urandom_range(0, 200) - 100);
      run_frame(0, wa, wb, hit, bz);
      chk("rand_busy_cycles", bz, 4);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/ball_collision_resolver.md
Name: ball_collision_resolver

Overview:
- Per-frame collision controller for a two-ball table.
- Once per frame it latches both balls' positions and velocities, then detects ball–ball overlap and cushion (wall) contact.
- It computes the post-collision velocities and drives them back to each ball's velocity write port with one-cycle write-enable pulses.
- It sits between the two ball motion blocks and the frame timing; its outputs connect directly to the balls' velocityWriteEnable/inVelocityX/inVelocityY.

Parameters:
- BALL_SIZE, 32, ball diameter in pixels; collision radius² = BALL_SIZE².
- TABLE_LEFT, 16, leftmost legal topLeft X.
- TABLE_RIGHT, 624, right cushion X; contact when X + BALL_SIZE >= TABLE_RIGHT.
- TABLE_TOP, 16, topmost legal topLeft Y.
- TABLE_BOTTOM, 464, bottom cushion Y; contact when Y + BALL_SIZE >= TABLE_BOTTOM.

Ports:
- clk  in  1  system clock
- resetN  in  1  asynchronous active-low reset
- startOfFrame  in  1  one-cycle pulse per frame; triggers evaluation
- posAX, posAY  in  11 signed each  ball A topLeft position
- velAX, velAY  in  11 signed each  ball A current velocity
- posBX, posBY  in  11 signed each  ball B topLeft position
- velBX, velBY  in  11 signed each  ball B current velocity
- writeEnableA  out  1  one-cycle pulse; load outVelA* into ball A
- outVelAX, outVelAY  out  11 signed each  new velocity for ball A
- writeEnableB  out  1  one-cycle pulse; load outVelB* into ball B
- outVelBX, outVelBY  out  11 signed each  new velocity for ball B
- hitPulse  out  1  one-cycle pulse when a ball–ball collision is resolved
- busy  out  1  high while the FSM is not in IDLE

Behaviour:
- Reset: resetN low asynchronously forces FSM to IDLE and clears every output and internal register to 0. Reset mid-evaluation aborts it; no write pulse follows.
- FSM states: IDLE, LATCH, CALC, RESOLVE, WRITE.
- IDLE -> LATCH when startOfFrame is sampled high. startOfFrame is ignored in every other state.
- LATCH: register all eight inputs.
  - dx = posBX-posAX and dy = posBY-posAY, 12-bit signed.
  - dvx = velBX-velAX and dvy = velBY-velAY, 12-bit signed.
- CALC: dist2 = dx²+dy², unsigned 24-bit; dot = dx*dvx+dy*dvy, signed 25-bit.
  - Products are full width; no truncation.
- RESOLVE, ball–ball step:
  - Collision condition: dist2 < BALL_SIZE² (strict) AND dot < 0 (approaching).
  - On collision, swap the full velocity vectors: A gets B's velocity, B gets A's (equal-mass elastic approximation).
  - dot >= 0 means the balls are separating or tangential: no swap, which prevents re-triggering while overlapped.
- RESOLVE, cushion step: applied per ball to the post-swap velocity, X and Y axes independent.
  - X <= TABLE_LEFT and vx < 0 -> vx = -vx.
  - X + BALL_SIZE >= TABLE_RIGHT and vx > 0 -> vx = -vx.
  - The same rules apply in Y with TABLE_TOP/TABLE_BOTTOM.
  - A ball moving away from a cushion is untouched.
  - Negating -1024 saturates to +1023.
- WRITE: for one cycle only:
  - writeEnableA is high iff ball A's resulting velocity differs from its latched velocity; writeEnableB likewise.
  - hitPulse is high iff a swap occurred.
  - Next state is IDLE.
- Latency: sof sampled high at edge N -> LATCH at N, CALC at N+1, RESOLVE at N+2, WRITE at N+3. Write pulses are visible during cycle N+3..N+4.
- outVel* update at entry to WRITE and hold their value until the next WRITE.
- busy is high from LATCH through WRITE inclusive; it is 4 cycles per frame.
- No write occurs on the startOfFrame cycle itself, so writes never collide with the balls' own frame update.

Test Plan:
- Head-on hit: A (100,100) v(64,0), B (120,100) v(0,0), pulse sof.
  - Response after 4 cycles: outVelA=(0,0), outVelB=(64,0); writeEnableA, writeEnableB, hitPulse each high exactly 1 cycle.
- Separating overlap: A (100,100) v(0,0), B (120,100) v(64,0), pulse sof.
  - dot = +1280, so no writes and no hitPulse; busy is high for 4 cycles.
- Right cushion: A (600,200) v(40,-10), B far away (300,300) v(0,0).
  - outVelA=(-40,-10), writeEnableA=1, writeEnableB=0, hitPulse=0.
- Corner plus saturation: A (10,10) v(-1024,-7), B (300,300) v(0,0).
  - outVelA=(1023,7), writeEnableA=1.
- sof while busy: second sof pulse 2 cycles after the first.
  - Ignored; exactly one WRITE cycle occurs and the FSM returns to IDLE.
- Reset mid-op: assert resetN low during CALC of the head-on case.
  - All outputs are 0 immediately; no write pulse after release; next sof evaluates normally.
